// File: rtl/prv32_pkg.sv
// Shared constants and types for the prv32 ID/EX slice.
//  - ALU function codes as carried on id_alufn / alu_alufn
//  - forward-select codes used by the operand forwarding muxes
//  - control bundle carried alongside an instruction into EX/MEM
package prv32_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RA_W_DEF = 5;
  localparam int unsigned ALUFN_W  = 4;
  localparam int unsigned SHAMT_W  = 5;

  localparam logic [ALUFN_W-1:0] ALUFN_ADD   = 4'b0000;
  localparam logic [ALUFN_W-1:0] ALUFN_SUB   = 4'b0001;
  localparam logic [ALUFN_W-1:0] ALUFN_PASSB = 4'b0011;
  localparam logic [ALUFN_W-1:0] ALUFN_OR    = 4'b0100;
  localparam logic [ALUFN_W-1:0] ALUFN_AND   = 4'b0101;
  localparam logic [ALUFN_W-1:0] ALUFN_XOR   = 4'b0111;
  localparam logic [ALUFN_W-1:0] ALUFN_SRL   = 4'b1000;
  localparam logic [ALUFN_W-1:0] ALUFN_SLL   = 4'b1001;
  localparam logic [ALUFN_W-1:0] ALUFN_SRA   = 4'b1010;
  localparam logic [ALUFN_W-1:0] ALUFN_SLT   = 4'b1101;
  localparam logic [ALUFN_W-1:0] ALUFN_SLTU  = 4'b1111;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
  } ex_ctrl_t;

endpackage

// File: rtl/prv32_fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports:
//  addr          registered source register address
//  regval        registered register-file value for that address
//  mem_*/wb_*    EX/MEM and MEM/WB writeback buses
//  value_c       forwarded operand (combinational)
// Priority: x0 never forwarded, then MEM, then WB, else register value.
module prv32_fwd_mux
  import prv32_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned RA_W   = RA_W_DEF,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] regval,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] value_c
);

  fwd_sel_e sel;

  // Select source; MEM is the younger result so it wins over WB
  always_comb begin
    sel = FWD_REG;
    if (FWD_EN && (addr != '0)) begin
      if (mem_regwrite && (mem_rd == addr)) begin
        sel = FWD_MEM;
      end else if (wb_regwrite && (wb_rd == addr)) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    value_c = regval;
    case (sel)
      FWD_MEM: value_c = mem_result;
      FWD_WB:  value_c = wb_result;
      default: value_c = regval;
    endcase
  end

endmodule

// File: rtl/prv32_id_ex_stage.sv
// ID/EX pipeline register and ALU operand select.
// Ports:
//  clk, rst                 clock, async active-high reset
//  id_valid / id_ready      decode handshake (id_ready=0 stalls IF/ID)
//  flush                    squash the ID instruction (taken branch in EX)
//  id_*                     decoded fields and register-file reads
//  mem_* / wb_*             forwarding buses from EX/MEM and MEM/WB
//  ex_valid, ex_pc, ex_rd, ex_regwrite/memread/memwrite   registered to EX/MEM
//  alu_a, alu_b, alu_shamt  ALU operands (combinational from stage regs + fwd)
//  alu_alufn                registered ALU function
//  ex_store_data            forwarded rs2 for stores
module prv32_id_ex_stage
  import prv32_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RA_W   = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic               flush,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RA_W-1:0]    id_rs1,
  input  logic [RA_W-1:0]    id_rs2,
  input  logic [RA_W-1:0]    id_rd,
  input  logic [ALUFN_W-1:0] id_alufn,
  input  logic               id_asel_pc,
  input  logic               id_bsel_imm,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               mem_regwrite,
  input  logic [RA_W-1:0]    mem_rd,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_regwrite,
  input  logic [RA_W-1:0]    wb_rd,
  input  logic [XLEN-1:0]    wb_result,
  output logic               ex_valid,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [ALUFN_W-1:0] alu_alufn,
  output logic [XLEN-1:0]    ex_pc,
  output logic [RA_W-1:0]    ex_rd,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic [XLEN-1:0]    ex_store_data
);

  ex_ctrl_t        ex_ctrl;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic            ex_asel_pc;
  logic            ex_bsel_imm;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            haz_c;
  logic            capture_c;

  // Load-use hazard: the load in EX has not produced its data yet
  always_comb begin
    haz_c = ex_valid & ex_ctrl.memread & (ex_rd != '0) & id_valid &
            ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

  // A flushed ID slot is discarded, so it never needs to be held
  assign id_ready  = flush | ~haz_c;
  assign capture_c = ~flush & ~haz_c & id_valid;

  // Valid/control/rd: anything other than a capture becomes a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
    end else if (capture_c) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite};
      ex_rd    <= id_rd;
    end else begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
    end
  end

  // Datapath regs only load on capture; bubbles leave them stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_asel_pc  <= 1'b0;
      ex_bsel_imm <= 1'b0;
      alu_alufn   <= ALUFN_ADD;
    end else if (capture_c) begin
      ex_pc       <= id_pc;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_asel_pc  <= id_asel_pc;
      ex_bsel_imm <= id_bsel_imm;
      alu_alufn   <= id_alufn;
    end
  end

  prv32_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .addr         (ex_rs1),
    .regval       (ex_rs1_data),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .value_c      (fwd_rs1)
  );

  prv32_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .addr         (ex_rs2),
    .regval       (ex_rs2_data),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .value_c      (fwd_rs2)
  );

  assign alu_a         = ex_asel_pc  ? ex_pc  : fwd_rs1;
  assign alu_b         = ex_bsel_imm ? ex_imm : fwd_rs2;
  assign alu_shamt     = alu_b[SHAMT_W-1:0];
  assign ex_store_data = fwd_rs2;

  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;

endmodule

// File: tb/tb_prv32_id_ex_stage.sv
// Scoreboard bench for prv32_id_ex_stage: stimulus pushes expectations from an
// instruction-level model, a negedge monitor pops and compares.
module tb_prv32_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1val, rs2val, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alufn;
    logic        asel, bsel, rw, mr, mw;
  } inst_t;

  typedef struct {
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } bus_t;

  typedef struct { logic valid; logic ready; } cyc_t;

  typedef struct {
    logic [31:0] a, b, sd, pc;
    logic [4:0]  rd, shamt;
    logic [3:0]  alufn;
    logic        rw, mr, mw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready, flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alufn;
  logic        id_asel_pc, id_bsel_imm, id_regwrite, id_memread, id_memwrite;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [4:0]  alu_shamt, ex_rd;
  logic [3:0]  alu_alufn;
  logic        ex_regwrite, ex_memread, ex_memwrite;

  prv32_id_ex_stage #(.XLEN(32), .RA_W(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .flush(flush),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alufn(id_alufn),
    .id_asel_pc(id_asel_pc), .id_bsel_imm(id_bsel_imm), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_alufn(alu_alufn), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  bit    last_stall = 1'b0;
  inst_t m_ex;
  inst_t cur_id;
  logic  cur_fl;
  bus_t  cur_bus;
  cyc_t  cyc_q[$];
  exp_t  exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic inst_t mk(logic v, logic [4:0] rs1, logic [31:0] rs1val,
                               logic [4:0] rs2, logic [31:0] rs2val, logic [31:0] imm,
                               logic [4:0] rd, logic [3:0] fn, logic asel, logic bsel,
                               logic rw, logic mr, logic mw);
    inst_t i;
    i.valid = v; i.pc = 32'h0000_1000; i.rs1 = rs1; i.rs1val = rs1val;
    i.rs2 = rs2; i.rs2val = rs2val; i.imm = imm; i.rd = rd; i.alufn = fn;
    i.asel = asel; i.bsel = bsel; i.rw = rw; i.mr = mr; i.mw = mw;
    return i;
  endfunction

  function automatic bus_t mkbus(logic mrw, logic [4:0] mrd, logic [31:0] mres,
                                 logic wrw, logic [4:0] wrd, logic [31:0] wres);
    bus_t b;
    b.mrw = mrw; b.mrd = mrd; b.mres = mres; b.wrw = wrw; b.wrd = wrd; b.wres = wres;
    return b;
  endfunction

  function automatic inst_t idle();
    return mk(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic inst_t rand_inst();
    inst_t i;
    i.valid  = ($urandom_range(0, 9) != 0);
    i.pc     = $urandom & 32'hFFFF_FFFC;
    i.rs1    = 5'($urandom_range(0, 7));
    i.rs2    = 5'($urandom_range(0, 7));
    i.rs1val = (i.rs1 == 5'd0) ? 32'd0 : $urandom;
    i.rs2val = (i.rs2 == 5'd0) ? 32'd0 : $urandom;
    i.imm    = $urandom;
    i.rd     = 5'($urandom_range(0, 7));
    i.alufn  = 4'($urandom_range(0, 15));
    i.asel   = ($urandom_range(0, 3) == 0);
    i.bsel   = 1'($urandom_range(0, 1));
    i.mr     = ($urandom_range(0, 2) == 0);
    i.rw     = i.mr | 1'($urandom_range(0, 1));
    i.mw     = !i.mr && ($urandom_range(0, 3) == 0);
    return i;
  endfunction

  function automatic bus_t rand_bus();
    return mkbus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
  endfunction

  // Value an instruction in EX actually sees for source s
  function automatic logic [31:0] fwd(logic [4:0] s, logic [31:0] v, bus_t b);
    if (s == 5'd0) return v;
    if (b.mrw && b.mrd == s) return b.mres;
    if (b.wrw && b.wrd == s) return b.wres;
    return v;
  endfunction

  // Load in EX whose result the ID instruction needs
  function automatic logic needs_load(inst_t ex, inst_t id);
    return ex.valid && ex.mr && ex.rd != 5'd0 && id.valid &&
           (ex.rd == id.rs1 || ex.rd == id.rs2);
  endfunction

  task automatic apply();
    id_valid = cur_id.valid; id_pc = cur_id.pc; id_rs1 = cur_id.rs1; id_rs2 = cur_id.rs2;
    id_rs1_data = cur_id.rs1val; id_rs2_data = cur_id.rs2val; id_imm = cur_id.imm;
    id_rd = cur_id.rd; id_alufn = cur_id.alufn; id_asel_pc = cur_id.asel;
    id_bsel_imm = cur_id.bsel; id_regwrite = cur_id.rw; id_memread = cur_id.mr;
    id_memwrite = cur_id.mw; flush = cur_fl;
    mem_regwrite = cur_bus.mrw; mem_rd = cur_bus.mrd; mem_result = cur_bus.mres;
    wb_regwrite = cur_bus.wrw; wb_rd = cur_bus.wrd; wb_result = cur_bus.wres;
  endtask

  // One clock: advance the model over the edge, drive new inputs, push expectations
  task automatic step(input inst_t i, input logic fl, input bus_t b);
    logic rdy;
    exp_t e;
    @(posedge clk);
    if (cur_fl || needs_load(m_ex, cur_id) || !cur_id.valid) m_ex.valid = 1'b0;
    else m_ex = cur_id;
    #1;
    cur_id = i; cur_fl = fl; cur_bus = b;
    apply();
    rdy = fl || !needs_load(m_ex, i);
    last_stall = !rdy;
    cyc_q.push_back('{valid: m_ex.valid, ready: rdy});
    if (m_ex.valid) begin
      e.a     = m_ex.asel ? m_ex.pc : fwd(m_ex.rs1, m_ex.rs1val, b);
      e.b     = m_ex.bsel ? m_ex.imm : fwd(m_ex.rs2, m_ex.rs2val, b);
      e.sd    = fwd(m_ex.rs2, m_ex.rs2val, b);
      e.shamt = e.b[4:0];
      e.pc    = m_ex.pc; e.rd = m_ex.rd; e.alufn = m_ex.alufn;
      e.rw    = m_ex.rw; e.mr = m_ex.mr; e.mw = m_ex.mw;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare whenever EX presents an instruction
  cyc_t mc;
  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cyc_q_underflow: got empty want entry (t=%0t)", $time);
      end else begin
        mc = cyc_q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(mc.valid));
        chk("id_ready", 32'(id_ready), 32'(mc.ready));
      end
      if (ex_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL exp_q_underflow: got ex_valid=1 want no instruction (t=%0t)", $time);
        end else begin
          me = exp_q.pop_front();
          chk("alu_a", alu_a, me.a);
          chk("alu_b", alu_b, me.b);
          chk("alu_shamt", 32'(alu_shamt), 32'(me.shamt));
          chk("store_data", ex_store_data, me.sd);
          chk("ex_pc", ex_pc, me.pc);
          chk("ex_rd", 32'(ex_rd), 32'(me.rd));
          chk("alufn", 32'(alu_alufn), 32'(me.alufn));
          chk("ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite}), 32'({me.rw, me.mr, me.mw}));
        end
      end else begin
        chk("bubble_ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite}), 32'd0);
        chk("bubble_rd", 32'(ex_rd), 32'd0);
      end
    end
  end

  inst_t t_i;
  bus_t  zb;

  initial begin
    zb = mkbus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    cur_id = idle(); cur_fl = 1'b0; cur_bus = zb; m_ex = idle();
    apply();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_alufn", 32'(alu_alufn), 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    rst = 1'b0;
    step(idle(), 1'b0, zb);
    mon_en = 1'b1;

    // ADDI x5,x0,7
    step(mk(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd7, 5'd5, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, zb);
    step(idle(), 1'b0, zb);
    #1;
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_a", alu_a, 32'd0);
    chk("addi_b", alu_b, 32'd7);
    chk("addi_fn", 32'(alu_alufn), 32'd0);
    chk("addi_rd", 32'(ex_rd), 32'd5);

    // MEM beats WB for the same register
    step(mk(1'b1, 5'd3, 32'd1, 5'd0, 32'd0, 32'd0, 5'd9, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, zb);
    step(idle(), 1'b0, mkbus(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB));
    #1;
    chk("mem_over_wb", alu_a, 32'hAA);

    // Load-use: LW x4 then ADD x6,x4,x4
    step(mk(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 32'd8, 5'd4, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, zb);
    t_i = mk(1'b1, 5'd4, 32'h55, 5'd4, 32'h55, 32'd0, 5'd6, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(t_i, 1'b0, zb);
    #1;
    chk("lu_stall", 32'(id_ready), 32'd0);
    step(t_i, 1'b0, zb);
    #1;
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_release", 32'(id_ready), 32'd1);
    step(idle(), 1'b0, mkbus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1234));
    #1;
    chk("lu_valid", 32'(ex_valid), 32'd1);
    chk("lu_fwd_a", alu_a, 32'h1234);
    chk("lu_fwd_b", alu_b, 32'h1234);
    chk("lu_rd", 32'(ex_rd), 32'd6);

    // Flush together with hazard
    step(mk(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 32'd8, 5'd4, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, zb);
    step(t_i, 1'b1, zb);
    #1;
    chk("fl_ready", 32'(id_ready), 32'd1);
    step(mk(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd3, 5'd7, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, zb);
    #1;
    chk("fl_bubble", 32'(ex_valid), 32'd0);
    chk("fl_regwrite", 32'(ex_regwrite), 32'd0);
    step(idle(), 1'b0, zb);
    #1;
    chk("fl_next_valid", 32'(ex_valid), 32'd1);
    chk("fl_next_rd", 32'(ex_rd), 32'd7);
    chk("fl_next_b", alu_b, 32'd3);

    // x0 never forwarded
    step(mk(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, zb);
    step(idle(), 1'b0, mkbus(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE));
    #1;
    chk("x0_store", ex_store_data, 32'd0);
    chk("x0_b", alu_b, 32'd0);
    chk("x0_shamt", 32'(alu_shamt), 32'd0);
    step(mk(1'b1, 5'd2, 32'h9, 5'd0, 32'd0, 32'h0000_0125, 5'd8, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, zb);
    step(idle(), 1'b0, zb);
    #1;
    chk("shamt_imm", 32'(alu_shamt), 32'd5);

    // Randomized traffic; a stalled instruction is held by upstream
    for (int n = 0; n < 400; n++) begin
      t_i = last_stall ? cur_id : rand_inst();
      step(t_i, ($urandom_range(0, 9) == 0), rand_bus());
    end

    // Reset mid-stream, asserted between edges
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_a", alu_a, 32'd0);
    chk("mid_rst_b", alu_b, 32'd0);
    chk("mid_rst_ready", 32'(id_ready), 32'd1);
    cyc_q.delete();
    exp_q.delete();
    m_ex = idle(); cur_id = idle(); cur_fl = 1'b0; cur_bus = rand_bus(); last_stall = 1'b0;
    apply();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(idle(), 1'b0, zb);
    mon_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      t_i = last_stall ? cur_id : rand_inst();
      step(t_i, ($urandom_range(0, 9) == 0), rand_bus());
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
